// File: rtl/audio_pkg.sv
// audio_pkg: shared audio-path widths, midscale value and envelope state encoding
package audio_pkg;
    localparam int PCM_W = 12;
    localparam int ENV_W = 8;
    localparam logic [PCM_W-1:0] PCM_MID = 12'd2048;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;
endpackage

// File: rtl/env_prescaler.sv
// env_prescaler: per-state step divider, ticks once every D cycles and restarts on clear
module env_prescaler
    import audio_pkg::*;
#(
    parameter int C_attack_delay  = 64,
    parameter int C_decay_delay   = 128,
    parameter int C_release_delay = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [2:0] sel,
    output logic       tick
);
    localparam int MAX_AD = C_attack_delay > C_decay_delay ? C_attack_delay : C_decay_delay;
    localparam int MAX_D  = MAX_AD > C_release_delay ? MAX_AD : C_release_delay;
    localparam int W      = MAX_D > 1 ? $clog2(MAX_D) : 1;
    localparam logic [W-1:0] A_LAST = W'(C_attack_delay - 1);
    localparam logic [W-1:0] D_LAST = W'(C_decay_delay - 1);
    localparam logic [W-1:0] R_LAST = W'(C_release_delay - 1);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_last;

    // terminal count for the delay of the selected state
    always_comb begin
        w_last = sel == ATTACK ? A_LAST : sel == DECAY ? D_LAST : R_LAST;
        tick   = r_cnt == w_last;
    end

    // count 0..D-1, wrapping on tick and restarting whenever the state changes
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (clear || tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR gain generator and midscale-centred PCM amplitude scaler
module adsr_envelope
    import audio_pkg::*;
#(
    parameter int C_attack_delay  = 64,
    parameter int C_decay_delay   = 128,
    parameter int C_release_delay = 256,
    parameter int C_sustain       = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gate,
    input  logic [11:0] pcm_in,
    output logic [11:0] pcm_out,
    output logic [7:0]  env,
    output logic        busy
);
    localparam logic [ENV_W-1:0] SUS     = 8'(C_sustain);
    localparam logic [ENV_W-1:0] ENV_MAX = 8'hFF;

    env_state_t         r_state;
    env_state_t         w_next;
    logic [ENV_W-1:0]   r_env;
    logic [ENV_W-1:0]   w_env_next;
    logic [PCM_W-1:0]   r_pcm;
    logic               w_tick;
    logic signed [12:0] w_s;
    logic signed [20:0] w_prod;

    env_prescaler #(
        .C_attack_delay (C_attack_delay),
        .C_decay_delay  (C_decay_delay),
        .C_release_delay(C_release_delay)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(w_next != r_state),
        .sel  (r_state),
        .tick (w_tick)
    );

    // next-state rules; gate changes take priority over level-based exits
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (gate) w_next = ATTACK;
            ATTACK:  if (!gate) w_next = RELEASE; else if (r_env == ENV_MAX) w_next = DECAY;
            DECAY:   if (!gate) w_next = RELEASE; else if (r_env == SUS) w_next = SUSTAIN;
            SUSTAIN: if (!gate) w_next = RELEASE;
            RELEASE: if (gate) w_next = ATTACK; else if (r_env == '0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // one saturating envelope step per prescaler tick, direction set by the state
    always_comb begin
        w_env_next = !w_tick ? r_env :
                     (r_state == ATTACK && r_env != ENV_MAX) ? r_env + 8'd1 :
                     (r_state == DECAY && r_env != SUS && r_env != '0) ? r_env - 8'd1 :
                     (r_state == RELEASE && r_env != '0) ? r_env - 8'd1 : r_env;
    end

    // signed sample about midscale times gain; the product always fits 21 bits
    always_comb begin
        w_s    = $signed({1'b0, pcm_in}) - 13'sd2048;
        w_prod = 21'(w_s) * 21'($signed({1'b0, r_env}));
    end

    // state, level and output sample all advance on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_env   <= '0;
            r_pcm   <= PCM_MID;
        end else begin
            r_state <= w_next;
            r_env   <= w_env_next;
            r_pcm   <= PCM_MID + 12'(w_prod >>> 8);
        end
    end

    assign pcm_out = r_pcm;
    assign env     = r_env;
    assign busy    = r_state != IDLE;
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed scenarios plus randomized gate/pcm run against a reference model
module tb_adsr_envelope;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] pcm_in = 12'd2048;
    logic [3:0]  gate = 4'd0;
    logic [7:0]  env_o [4];
    logic [11:0] pcm_o [4];
    logic        busy_o [4];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    localparam int AD [4] = '{2, 1, 1, 1};
    localparam int DD [4] = '{3, 1, 1, 1};
    localparam int RD [4] = '{4, 1, 1, 1};
    localparam int SU [4] = '{100, 128, 255, 0};

    int m_mode [4];
    int m_lvl [4];
    int m_entry [4];
    int m_pcm [4];

    always #5 clk = ~clk;

    adsr_envelope #(.C_attack_delay(2), .C_decay_delay(3), .C_release_delay(4), .C_sustain(100)) u0 (
        .clk(clk), .reset(reset), .gate(gate[0]), .pcm_in(pcm_in),
        .pcm_out(pcm_o[0]), .env(env_o[0]), .busy(busy_o[0]));
    adsr_envelope #(.C_attack_delay(1), .C_decay_delay(1), .C_release_delay(1), .C_sustain(128)) u1 (
        .clk(clk), .reset(reset), .gate(gate[1]), .pcm_in(pcm_in),
        .pcm_out(pcm_o[1]), .env(env_o[1]), .busy(busy_o[1]));
    adsr_envelope #(.C_attack_delay(1), .C_decay_delay(1), .C_release_delay(1), .C_sustain(255)) u2 (
        .clk(clk), .reset(reset), .gate(gate[2]), .pcm_in(pcm_in),
        .pcm_out(pcm_o[2]), .env(env_o[2]), .busy(busy_o[2]));
    adsr_envelope #(.C_attack_delay(1), .C_decay_delay(1), .C_release_delay(1), .C_sustain(0)) u3 (
        .clk(clk), .reset(reset), .gate(gate[3]), .pcm_in(pcm_in),
        .pcm_out(pcm_o[3]), .env(env_o[3]), .busy(busy_o[3]));

    // modes: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_mode[i] = 0; m_lvl[i] = 0; m_entry[i] = cyc; m_pcm[i] = 2048;
        end
    endfunction

    // steps land on edges that are whole multiples of D after the mode was entered
    function automatic void model_step(int i);
        int d, nm, nl;
        bit t;
        d = m_mode[i] == 1 ? AD[i] : m_mode[i] == 2 ? DD[i] : RD[i];
        t = (m_mode[i] == 1 || m_mode[i] == 2 || m_mode[i] == 4) && ((cyc - m_entry[i]) % d == 0);
        nm = m_mode[i];
        nl = m_lvl[i];
        m_pcm[i] = (2048 + (((int'(pcm_in) - 2048) * m_lvl[i]) >>> 8)) & 4095;
        case (m_mode[i])
            0: if (gate[i]) nm = 1;
            1: begin
                if (t && nl < 255) nl = nl + 1;
                if (!gate[i]) nm = 4; else if (m_lvl[i] == 255) nm = 2;
            end
            2: begin
                if (t && nl != SU[i] && nl > 0) nl = nl - 1;
                if (!gate[i]) nm = 4; else if (m_lvl[i] == SU[i]) nm = 3;
            end
            3: if (!gate[i]) nm = 4;
            default: begin
                if (t && nl > 0) nl = nl - 1;
                if (gate[i]) nm = 1; else if (m_lvl[i] == 0) nm = 0;
            end
        endcase
        if (nm != m_mode[i]) m_entry[i] = cyc;
        m_mode[i] = nm;
        m_lvl[i] = nl;
    endfunction

    task automatic tick_all();
        @(posedge clk);
        cyc++;
        if (reset) model_reset();
        else for (int i = 0; i < 4; i++) model_step(i);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pcm_in = 12'd4095;
        gate = 4'd0;
        repeat (3) tick_all();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (env_o[i] !== 8'd0) begin n_bad++; $display("FAIL reset_env[%0d]: got %0d want 0", i, env_o[i]); end
            n_cmp++; if (pcm_o[i] !== 12'd2048) begin n_bad++; $display("FAIL reset_pcm[%0d]: got %0d want 2048", i, pcm_o[i]); end
            n_cmp++; if (busy_o[i] !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %0b want 0", i, busy_o[i]); end
        end
        for (int k = 0; k < 1000; k++) begin
            tick_all();
            if (k % 100 == 99) begin
                for (int i = 0; i < 4; i++) begin
                    n_cmp++;
                    if (env_o[i] !== 8'd0 || pcm_o[i] !== 12'd2048 || busy_o[i] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL idle_hold[%0d]: env %0d pcm %0d busy %0b want 0/2048/0", i, env_o[i], pcm_o[i], busy_o[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_envelope();
        int n;
        gate[0] = 1'b1;
        tick_all();
        n_cmp++; if (busy_o[0] !== 1'b1) begin n_bad++; $display("FAIL attack_busy: got %0b want 1", busy_o[0]); end
        n = 0;
        while (env_o[0] !== 8'd255 && n < 2000) begin tick_all(); n++; end
        n_cmp++; if (n != 510) begin n_bad++; $display("FAIL attack_time: got %0d want 510", n); end
        n = 0;
        while (env_o[0] !== 8'd100 && n < 2000) begin tick_all(); n++; end
        n_cmp++; if (n != 466) begin n_bad++; $display("FAIL decay_time: got %0d want 466", n); end
        repeat (50) tick_all();
        n_cmp++; if (env_o[0] !== 8'd100) begin n_bad++; $display("FAIL sustain_hold: got %0d want 100", env_o[0]); end
        gate[0] = 1'b0;
        tick_all();
        n = 0;
        while (env_o[0] !== 8'd0 && n < 2000) begin tick_all(); n++; end
        n_cmp++; if (n != 400) begin n_bad++; $display("FAIL release_time: got %0d want 400", n); end
        n_cmp++; if (busy_o[0] !== 1'b1) begin n_bad++; $display("FAIL release_busy: got %0b want 1", busy_o[0]); end
        tick_all();
        n_cmp++; if (busy_o[0] !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %0b want 0", busy_o[0]); end
    endtask

    task automatic test_scaling();
        int pv [4] = '{4095, 0, 2048, 2047};
        int ev [4] = '{3071, 1024, 2048, 2047};
        gate[1] = 1'b1;
        repeat (450) tick_all();
        n_cmp++; if (env_o[1] !== 8'd128) begin n_bad++; $display("FAIL scale_env: got %0d want 128", env_o[1]); end
        for (int k = 0; k < 4; k++) begin
            pcm_in = 12'(pv[k]);
            tick_all();
            n_cmp++; if (pcm_o[1] !== 12'(ev[k])) begin n_bad++; $display("FAIL scale_pcm_%0d: got %0d want %0d", pv[k], pcm_o[1], ev[k]); end
        end
    endtask

    task automatic test_edge_sustain();
        int n;
        gate[2] = 1'b1;
        gate[3] = 1'b1;
        n = 0;
        while (env_o[2] !== 8'd255 && n < 600) begin tick_all(); n++; end
        n_cmp++; if (n >= 600) begin n_bad++; $display("FAIL sus255_reach: got timeout want env 255"); end
        for (int k = 0; k < 20; k++) begin
            tick_all();
            n_cmp++; if (env_o[2] !== 8'd255) begin n_bad++; $display("FAIL sus255_hold: got %0d want 255", env_o[2]); end
        end
        repeat (600) tick_all();
        n_cmp++; if (env_o[3] !== 8'd0 || busy_o[3] !== 1'b1) begin n_bad++; $display("FAIL sus0_hold: env %0d busy %0b want 0/1", env_o[3], busy_o[3]); end
        for (int k = 0; k < 4; k++) begin
            pcm_in = 12'($urandom);
            tick_all();
            n_cmp++; if (pcm_o[3] !== 12'd2048) begin n_bad++; $display("FAIL sus0_pcm: got %0d want 2048", pcm_o[3]); end
        end
        gate[3] = 1'b0;
        tick_all();
        n_cmp++; if (busy_o[3] !== 1'b1) begin n_bad++; $display("FAIL sus0_release: got %0b want 1", busy_o[3]); end
        tick_all();
        n_cmp++; if (busy_o[3] !== 1'b0) begin n_bad++; $display("FAIL sus0_idle: got %0b want 0", busy_o[3]); end
    endtask

    task automatic test_retrigger();
        int n;
        gate[0] = 1'b1;
        n = 0;
        while (env_o[0] !== 8'd70 && n < 500) begin tick_all(); n++; end
        gate[0] = 1'b0;
        n = 0;
        while (env_o[0] !== 8'd60 && n < 500) begin tick_all(); n++; end
        n_cmp++; if (env_o[0] !== 8'd60) begin n_bad++; $display("FAIL retrig_setup: got %0d want 60", env_o[0]); end
        gate[0] = 1'b1;
        tick_all();
        n_cmp++; if (env_o[0] !== 8'd60) begin n_bad++; $display("FAIL retrig_e1: got %0d want 60", env_o[0]); end
        tick_all();
        n_cmp++; if (env_o[0] !== 8'd60) begin n_bad++; $display("FAIL retrig_e2: got %0d want 60", env_o[0]); end
        tick_all();
        n_cmp++; if (env_o[0] !== 8'd61) begin n_bad++; $display("FAIL retrig_step: got %0d want 61", env_o[0]); end
    endtask

    task automatic test_async_reset();
        int n;
        gate[0] = 1'b0;
        n = 0;
        while (busy_o[0] !== 1'b0 && n < 1000) begin tick_all(); n++; end
        gate[0] = 1'b1;
        n = 0;
        while (env_o[0] !== 8'd37 && n < 500) begin tick_all(); n++; end
        n_cmp++; if (env_o[0] !== 8'd37) begin n_bad++; $display("FAIL areset_setup: got %0d want 37", env_o[0]); end
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (env_o[0] !== 8'd0) begin n_bad++; $display("FAIL areset_env: got %0d want 0", env_o[0]); end
        n_cmp++; if (pcm_o[0] !== 12'd2048) begin n_bad++; $display("FAIL areset_pcm: got %0d want 2048", pcm_o[0]); end
        n_cmp++; if (busy_o[0] !== 1'b0) begin n_bad++; $display("FAIL areset_busy: got %0b want 0", busy_o[0]); end
        @(negedge clk);
        reset = 1'b0;
        tick_all();
        n_cmp++; if (busy_o[0] !== 1'b1 || env_o[0] !== 8'd0) begin n_bad++; $display("FAIL areset_restart: busy %0b env %0d want 1/0", busy_o[0], env_o[0]); end
        tick_all();
        tick_all();
        n_cmp++; if (env_o[0] !== 8'd1) begin n_bad++; $display("FAIL areset_step: got %0d want 1", env_o[0]); end
    endtask

    task automatic test_random();
        int rate;
        for (int c = 0; c < 3000; c++) begin
            rate = (c / 500) % 2 == 0 ? 60 : 2;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, rate - 1) == 0) gate[i] = ~gate[i];
            pcm_in = 12'($urandom);
            tick_all();
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (env_o[i] !== 8'(m_lvl[i])) begin n_bad++; $display("FAIL rand_env[%0d] c%0d: got %0d want %0d", i, c, env_o[i], m_lvl[i]); end
                n_cmp++; if (busy_o[i] !== (m_mode[i] != 0)) begin n_bad++; $display("FAIL rand_busy[%0d] c%0d: got %0b want %0b", i, c, busy_o[i], m_mode[i] != 0); end
                n_cmp++; if (pcm_o[i] !== 12'(m_pcm[i])) begin n_bad++; $display("FAIL rand_pcm[%0d] c%0d: got %0d want %0d", i, c, pcm_o[i], m_pcm[i]); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_envelope();
        test_scaling();
        test_edge_sustain();
        test_retrigger();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
